// File: rtl/bus_unit.sv
// bus_unit -- bridges a clock-enabled byte core onto a request/ready memory bus.
// Each core cycle becomes exactly one memory access. The core is held, with
// core_ce low, until that access completes or times out.
// Optional feature: define BUS_POSTED_WRITE_EN to add a one-entry posted
// write buffer. With the buffer, a write completes for the core in two clocks
// and is drained to memory in the background.
module bus_unit #(
   parameter int unsigned TIMEOUT = 255,
   parameter logic [7:0]  RD_FILL = 8'hFF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] core_address,
   input  logic [7:0]  core_out,
   input  logic        core_wren,
   output logic [7:0]  core_in,
   output logic        core_ce,
   output logic [19:0] mem_address,
   output logic [7:0]  mem_wdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        bus_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter value seen in the last waiting cycle before an abort
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

   state_t       state_r;
   state_t       next_state_s;
   logic [7:0]   wait_cnt_r;
   logic [7:0]   core_in_r;
   logic [19:0]  mem_address_r;
   logic [7:0]   mem_wdata_r;
   logic         mem_we_r;
   logic         bus_error_r;
   logic         core_ce_s;
   logic         mem_req_s;

   logic         fsm_req_s;   // FSM is running a read/write access
   logic         drain_s;     // posted write buffer is draining
   logic         bus_busy_s;  // some access currently owns mem_req
   logic         timeout_s;   // the active access hits its wait limit this cycle
   logic         capture_s;   // IDLE may accept the core's request this cycle
   logic         post_s;      // accepted request goes into the posted buffer
   logic         load_s;      // request parameters are captured this cycle

   assign fsm_req_s  = (state_r == REQ);
   assign bus_busy_s = fsm_req_s | drain_s;
   // A ready in the last allowed cycle completes the access, so ready masks the abort
   assign timeout_s  = bus_busy_s & ~mem_ready & (wait_cnt_r == TMO_LAST);
   assign load_s     = (state_r == IDLE) & capture_s;

`ifdef BUS_POSTED_WRITE_EN
   logic buf_valid_r;

   // The buffered write owns the bus while valid; reads and writes wait for it
   assign drain_s   = buf_valid_r;
   assign capture_s = ~buf_valid_r;
   assign post_s    = core_wren;

   // Posted write buffer occupancy: filled from IDLE, emptied on drain completion or abort
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid_r <= 1'b0;
      end else if (load_s && post_s) begin
         buf_valid_r <= 1'b1;
      end else if (drain_s && (mem_ready || timeout_s)) begin
         buf_valid_r <= 1'b0;
      end else begin
         buf_valid_r <= buf_valid_r;
      end
   end
`else
   assign drain_s   = 1'b0;
   assign capture_s = 1'b1;
   assign post_s    = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: IDLE -> REQ (or DONE for a posted write) -> DONE -> IDLE
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (capture_s) begin
               if (post_s) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = REQ;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         REQ: begin
            if (mem_ready || timeout_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = REQ;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Output decode: the core advances only in DONE; mem_req follows any bus owner
   always_comb begin
      core_ce_s = 1'b0;
      mem_req_s = bus_busy_s;
      case (state_r)
         IDLE:    core_ce_s = 1'b0;
         REQ:     core_ce_s = 1'b0;
         DONE:    core_ce_s = 1'b1;
         default: core_ce_s = 1'b0;
      endcase
   end

   // Wait counter: cleared when an access starts, counts the cycles without ready
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_r <= 8'd0;
      end else if (load_s) begin
         wait_cnt_r <= 8'd0;
      end else if (bus_busy_s && !mem_ready) begin
         wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Memory-side request parameters: loaded only in IDLE, so frozen while mem_req is high
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_address_r <= 20'd0;
         mem_wdata_r   <= 8'd0;
         mem_we_r      <= 1'b0;
      end else if (load_s) begin
         mem_address_r <= core_address;
         mem_wdata_r   <= core_out;
         mem_we_r      <= core_wren;
      end else begin
         mem_address_r <= mem_address_r;
         mem_wdata_r   <= mem_wdata_r;
         mem_we_r      <= mem_we_r;
      end
   end

   // Read data to the core: memory byte on completion, fill byte on abort, held otherwise
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core_in_r <= 8'h00;
      end else if (fsm_req_s && !mem_we_r && mem_ready) begin
         core_in_r <= mem_rdata;
      end else if (fsm_req_s && !mem_we_r && timeout_s) begin
         core_in_r <= RD_FILL;
      end else begin
         core_in_r <= core_in_r;
      end
   end

   // Bus error: one-cycle pulse for every aborted access
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_error_r <= 1'b0;
      end else begin
         bus_error_r <= timeout_s;
      end
   end

   assign core_in     = core_in_r;
   assign core_ce     = core_ce_s;
   assign mem_address = mem_address_r;
   assign mem_wdata   = mem_wdata_r;
   assign mem_we      = mem_we_r;
   assign mem_req     = mem_req_s;
   assign bus_error   = bus_error_r;

endmodule

// File: doc/bus_unit.md
BUS_UNIT -- requirements
Module: bus_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for mem_ready before abort (1..255).
REQ-002 SHALL have parameter RD_FILL, default 8'hFF, byte returned to the core on an aborted read.
REQ-003 clock  in  1  single clock; all state on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 core_address  in  20  byte address driven by the core.
REQ-006 core_out  in  8  write byte from the core.
REQ-007 core_wren  in  1  1 = core cycle is a write, 0 = read.
REQ-008 core_in  out  8  read byte to the core's data input; registered.
REQ-009 core_ce  out  1  core clock-enable; the core advances only on edges where it is 1.
REQ-010 mem_address  out  20  memory-side address; registered.
REQ-011 mem_wdata  out  8  memory-side write byte; registered.
REQ-012 mem_req  out  1  memory access request; level, held until mem_ready or abort.
REQ-013 mem_we  out  1  qualifies mem_req as a write; stable while mem_req=1.
REQ-014 mem_rdata  in  8  read byte, valid on the cycle mem_ready=1.
REQ-015 mem_ready  in  1  memory accepts/completes the access this cycle.
REQ-016 bus_error  out  1  one-cycle pulse on each timeout abort.

Function
REQ-017 SHALL run FSM states IDLE, REQ, DONE; every core cycle is exactly one memory access.
REQ-018 IDLE: core_ce=0; SHALL capture core_address/core_out/core_wren into mem_address/mem_wdata/mem_we and go to REQ.
REQ-019 REQ: mem_req=1; on mem_ready=1 SHALL drop mem_req next edge, latch mem_rdata into core_in for reads (core_in unchanged for writes), go to DONE.
REQ-020 DONE: core_ce=1 for exactly one cycle, core_in stable; SHALL go to IDLE.
REQ-021 With zero-wait memory (mem_ready=1 first REQ cycle), one core cycle SHALL take exactly 3 clocks.
REQ-022 A wait counter SHALL clear on entering REQ and increment each REQ cycle with mem_ready=0; reaching TIMEOUT SHALL abort: mem_req drops, core_in<=RD_FILL (reads only), bus_error=1 for one cycle, go to DONE.
REQ-023 mem_ready=1 on the same cycle the counter reaches TIMEOUT SHALL count as completion, not abort.
REQ-024 mem_ready while mem_req=0 SHALL be ignored.
REQ-025 mem_address/mem_wdata/mem_we SHALL NOT change while mem_req=1.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, core_ce=0, core_in=8'h00, mem_req=0, mem_we=0, mem_address=0, mem_wdata=0, bus_error=0, counter 0, write buffer empty.
REQ-027 Reset during REQ SHALL abandon the access; no completion is reported after release.
REQ-028 First core_ce=1 after reset release SHALL occur no earlier than the 3rd rising edge.

Configuration
REQ-029 Macro BUS_POSTED_WRITE_EN SHALL enable a one-entry posted write buffer; without it writes follow REQ-018..020 exactly.
REQ-030 With it, a write in IDLE with buffer empty SHALL load the buffer and go directly to DONE (2 clocks); the buffer drains via mem_req/mem_we in parallel with the FSM.
REQ-031 With it, a read or a write while the buffer is full SHALL wait in IDLE (core_ce=0) until the drain completes; reads never bypass the buffered write.
REQ-032 With it, a drain timeout SHALL discard the write and pulse bus_error.

Verification
REQ-033 Read 20'h12345, mem_ready on first REQ cycle, mem_rdata=8'hA5 -> core_ce pulses on clock 3, core_in=8'hA5.
REQ-034 Write 8'h3C to 20'hFFFFF, mem_ready after 4 wait cycles -> mem_we=1, mem_wdata=8'h3C, address stable for all 5 REQ cycles, core_ce after 7 clocks.
REQ-035 Read, mem_ready held low, TIMEOUT=4 -> abort after 4 REQ cycles, bus_error one pulse, core_in=8'hFF.
REQ-036 reset_n low in the 2nd REQ cycle -> mem_req=0 same cycle, no core_ce and no bus_error after release until a new access.
REQ-037 BUS_POSTED_WRITE_EN: write 8'h11 to 20'h00010 then read 20'h00010 with memory 2-wait -> write done in 2 clocks, read issued only after drain, returns 8'h11.
